// File: rtl/alu_issue_ctrl.sv
// Operand-mux select sequencer: decodes the RV32I opcode into ALU1/ALU2 source selects,
// delays them PIPE_DEPTH cycles to meet the delayed PC, squashes on redirect, counts issues.
module alu_issue_ctrl #(
  parameter int REG_LEN    = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_LEN-1:0] instr,
  input  logic               instr_valid,
  input  logic               branch_taken,
  output logic               alu1_sel,
  output logic               alu2_sel,
  output logic               ex_valid,
  output logic               illegal,
  output logic               flush_busy,
  output logic [CNT_W-1:0]   issue_cnt
);

  typedef enum logic { ALU1_RS = 1'b0, ALU1_PC  = 1'b1 } alu1_sel_e;
  typedef enum logic { ALU2_RS2 = 1'b0, ALU2_IMM = 1'b1 } alu2_sel_e;
  typedef enum logic { ST_RUN = 1'b0, ST_FLUSH = 1'b1 } state_e;

  typedef struct packed {
    logic      valid;
    logic      illegal;
    alu1_sel_e a1;
    alu2_sel_e a2;
  } slot_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam int              FCNT_W    = $clog2(PIPE_DEPTH + 1);
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(PIPE_DEPTH);
  localparam slot_t           SLOT_EMPTY = '0;

  state_e            r_state, w_state_nxt;
  logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
  slot_t             r_slot [PIPE_DEPTH];
  slot_t             w_slot_in;
  logic [CNT_W-1:0]  r_issue_cnt;

  logic      w_legal;
  logic      w_accept;
  alu1_sel_e w_dec_a1;
  alu2_sel_e w_dec_a2;

  // Only the opcode field steers the operand muxes.
  logic w_unused_instr;
  assign w_unused_instr = ^instr[REG_LEN-1:7];

  // NOTE: every always_comb output gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_legal  = 1'b1;
    w_dec_a1 = ALU1_RS;
    w_dec_a2 = ALU2_RS2;
    case (instr[6:0])
      OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
        w_dec_a1 = ALU1_PC;
        w_dec_a2 = ALU2_IMM;
      end
      OPC_JALR, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_LUI, OPC_SYSTEM, OPC_MISC_MEM: begin
        w_dec_a2 = ALU2_IMM;
      end
      OPC_OP: ;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept = instr_valid && (r_state == ST_RUN) && !branch_taken;

  always_comb begin
    w_slot_in = SLOT_EMPTY;
    if (w_accept) begin
      w_slot_in.valid   = w_legal;
      w_slot_in.illegal = !w_legal;
      if (w_legal) begin
        w_slot_in.a1 = w_dec_a1;
        w_slot_in.a2 = w_dec_a2;
      end
    end
  end

  // NOTE: the slot array is a handful of flops whose valid bits gate the outputs, not a RAM,
  // so every entry is cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) r_slot[i] <= SLOT_EMPTY;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the pre-edge value of the
      // stage before it, which is what turns this loop into a shift register.
      r_slot[0] <= w_slot_in;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_slot[i] <= branch_taken ? SLOT_EMPTY : r_slot[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // A redirect during FLUSH restarts the window so the new path gets a full drain.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (branch_taken) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (branch_taken) begin
          w_fcnt_nxt = FCNT_LOAD;
        end else if (r_fcnt == FCNT_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = '0;
        end else begin
          w_fcnt_nxt = r_fcnt - FCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
    end else if (r_slot[PIPE_DEPTH-1].valid) begin
      r_issue_cnt <= r_issue_cnt + CNT_W'(1);
    end
  end

  assign alu1_sel   = r_slot[PIPE_DEPTH-1].a1;
  assign alu2_sel   = r_slot[PIPE_DEPTH-1].a2;
  assign ex_valid   = r_slot[PIPE_DEPTH-1].valid;
  assign illegal    = r_slot[PIPE_DEPTH-1].illegal;
  assign flush_busy = (r_state == ST_FLUSH);
  assign issue_cnt  = r_issue_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl (PIPE_DEPTH=2, CNT_W=4): the driver pushes the expected
// output slot for every instruction that should survive, a negedge monitor pops and compares.
module tb_alu_issue_ctrl;

  localparam int PD = 2;
  localparam int CW = 4;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] SYS   = 7'b1110011;
  localparam logic [6:0] FENCE = 7'b0001111;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   instr = '0;
  logic          instr_valid = 1'b0;
  logic          branch_taken = 1'b0;
  logic          alu1_sel, alu2_sel, ex_valid, illegal, flush_busy;
  logic [CW-1:0] issue_cnt;

  alu_issue_ctrl #(.REG_LEN(32), .PIPE_DEPTH(PD), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .branch_taken (branch_taken),
    .alu1_sel     (alu1_sel),
    .alu2_sel     (alu2_sel),
    .ex_valid     (ex_valid),
    .illegal      (illegal),
    .flush_busy   (flush_busy),
    .issue_cnt    (issue_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          a1;
    logic          a2;
    logic          ill;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] exp_cnt = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  // Hand table of the expected mux choice per opcode.
  function automatic void ref_dec(input logic [6:0] op, output logic a1, output logic a2,
                                  output logic ill);
    a1 = 1'b0; a2 = 1'b0; ill = 1'b0;
    case (op)
      AUIPC, JAL, BR: begin a1 = 1'b1; a2 = 1'b1; end
      JALR, LOAD, STORE, OPIMM, LUI, SYS, FENCE: a2 = 1'b1;
      OP: ;
      default: ill = 1'b1;
    endcase
  endfunction

  // One cycle of stimulus. keep: this instruction must reach the output (hand-derived,
  // already accounting for FSM state and later squash). fb: flush_busy expected this cycle.
  task automatic drive(input bit v, input logic [6:0] op, input bit bt, input bit keep,
                       input bit fb);
    exp_t e;
    check("flush_busy", {31'd0, flush_busy}, {31'd0, fb});
    instr_valid  = v;
    instr        = {25'($urandom()), op};
    branch_taken = bt;
    if (keep) begin
      e.cyc = cyc + PD;
      ref_dec(op, e.a1, e.a2, e.ill);
      e.cnt = exp_cnt;
      if (!e.ill) exp_cnt = exp_cnt + 4'd1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ex_valid || illegal)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {30'd0, ex_valid, illegal}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_cycle", cyc, e.cyc);
        check("ex_valid", {31'd0, ex_valid}, {31'd0, !e.ill});
        check("illegal", {31'd0, illegal}, {31'd0, e.ill});
        if (!e.ill) begin
          check("alu1_sel", {31'd0, alu1_sel}, {31'd0, e.a1});
          check("alu2_sel", {31'd0, alu2_sel}, {31'd0, e.a2});
        end
        check("issue_cnt", {28'd0, issue_cnt}, {28'd0, e.cnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while a valid instruction is presented.
    instr_valid = 1'b1;
    instr       = {25'd0, OP};
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_alu1_sel", {31'd0, alu1_sel}, 32'd0);
      check("rst_alu2_sel", {31'd0, alu2_sel}, 32'd0);
      check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
      check("rst_issue_cnt", {28'd0, issue_cnt}, 32'd0);
    end
    rst         = 1'b0;
    instr_valid = 1'b0;

    // Stream of every legal opcode class, with one idle gap.
    drive(0, OP,    0, 0, 0);
    drive(1, OP,    0, 1, 0);
    drive(1, AUIPC, 0, 1, 0);
    drive(1, OPIMM, 0, 1, 0);
    drive(1, JAL,   0, 1, 0);
    drive(0, JAL,   0, 0, 0);
    drive(1, BR,    0, 1, 0);
    drive(1, JALR,  0, 1, 0);
    drive(1, LOAD,  0, 1, 0);
    drive(1, STORE, 0, 1, 0);
    drive(1, LUI,   0, 1, 0);
    drive(1, SYS,   0, 1, 0);
    drive(1, FENCE, 0, 1, 0);

    // Single redirect: the instr before it and the one with it are lost, two FLUSH cycles.
    drive(1, OPIMM, 0, 1, 0);
    drive(1, OPIMM, 0, 0, 0);
    drive(1, OPIMM, 1, 0, 0);
    drive(1, OPIMM, 0, 0, 1);
    drive(1, OPIMM, 0, 0, 1);
    drive(1, OPIMM, 0, 1, 0);
    drive(1, OPIMM, 0, 1, 0);

    // Back-to-back redirect extends FLUSH by one cycle.
    drive(1, OPIMM, 0, 0, 0);
    drive(1, OP,    1, 0, 0);
    drive(1, OP,    1, 0, 1);
    drive(1, OP,    0, 0, 1);
    drive(1, OP,    0, 0, 1);
    drive(1, AUIPC, 0, 1, 0);
    drive(1, LUI,   0, 1, 0);

    // Illegal at the output in the same cycle as a redirect is still reported.
    drive(1, BAD,   0, 1, 0);
    drive(1, OP,    0, 0, 0);
    drive(1, OP,    1, 0, 0);
    drive(1, OP,    0, 0, 1);
    drive(1, OP,    0, 0, 1);
    drive(1, OP,    0, 1, 0);
    drive(1, OP,    0, 1, 0);

    // Standalone illegal; invalid illegal opcode ignored; count does not move.
    drive(1, BAD,   0, 1, 0);
    drive(0, BAD,   0, 0, 0);
    drive(1, OPIMM, 0, 1, 0);
    drive(0, OP,    0, 0, 0);
    drive(0, OP,    0, 0, 0);

    // Asynchronous reset in the middle of FLUSH.
    drive(1, OP, 0, 0, 0);
    drive(1, OP, 1, 0, 0);
    instr_valid  = 1'b0;
    branch_taken = 1'b0;
    check("flush_before_rst", {31'd0, flush_busy}, 32'd1);
    check("cnt_before_rst", {28'd0, issue_cnt}, {28'd0, exp_cnt});
    check("sb_empty_at_rst", sb.size(), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_flush_busy", {31'd0, flush_busy}, 32'd0);
    check("async_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("async_illegal", {31'd0, illegal}, 32'd0);
    check("async_issue_cnt", {28'd0, issue_cnt}, 32'd0);
    sb.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 17 legal instrs: counter runs 0..15, wraps to 0, ends at 1.
    for (int i = 0; i < 17; i++) drive(1, OP, 0, 1, 0);
    repeat (PD + 2) drive(0, OP, 0, 0, 0);
    check("cnt_after_wrap", {28'd0, issue_cnt}, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
